// File: rtl/stopwatch_display_if.sv
// Bus between the stopwatch core side and the display driver:
// time/run/lap in, multiplexed 7-segment pins and freeze flag out.
interface stopwatch_display_if;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic       run;
  logic       lap;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frozen;

  modport master (output seconds, minutes, run, lap, input seg, an, dp, frozen);
  modport slave  (input seconds, minutes, run, lap, output seg, an, dp, frozen);
endinterface

// File: rtl/stopwatch_display.sv
// MM.SS multiplexed 7-segment driver: snapshot/lap freeze, binary-to-BCD,
// digit scan and registered pin drive.

module stopwatch_display_bcd2 (
  input  logic [5:0]      v,
  output logic [1:0][3:0] d    // d[1] = tens, d[0] = ones
);
  localparam logic [3:0] DASH = 4'hA;

  always_comb begin
    d[1] = DASH;
    d[0] = DASH;
    if (v <= 6'd59) begin
      d[1] = 4'(v / 6'd10);
      d[0] = 4'(v % 6'd10);
    end
  end
endmodule

module stopwatch_display #(
  parameter int SCAN_DIV   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic reset,
  stopwatch_display_if.slave sw
);
  localparam int             DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [6:0]     POL7     = {7{ACTIVE_LOW}};
  localparam logic [3:0]     POL4     = {4{ACTIVE_LOW}};

  logic                 frozen_q;
  logic [1:0][5:0]      snap_q;     // [1] minutes, [0] seconds
  logic [1:0][1:0][3:0] dig_nxt;    // [field][tens/ones]
  logic [3:0][3:0]      dig_q;      // 0 = sec ones .. 3 = min tens
  logic [DW-1:0]        div_q;
  logic [1:0]           idx_q;
  logic                 blink_q;
  logic [6:0]           seg_q;
  logic [3:0]           an_q;
  logic                 dp_q;
  logic                 dp_on;

  // Any code outside 0..9 is the out-of-range dash.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  generate
    for (genvar f = 0; f < 2; f++) begin : g_bcd
      stopwatch_display_bcd2 u_bcd (.v(snap_q[f]), .d(dig_nxt[f]));
    end
  endgenerate

  // Separator: steady with run while live, blinking per frame while frozen.
  assign dp_on = (idx_q == 2'd2) && (frozen_q ? blink_q : sw.run);

  always_ff @(posedge clk) begin
    if (reset) begin
      frozen_q <= 1'b0;
      snap_q   <= '0;
      dig_q    <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      blink_q  <= 1'b0;
      seg_q    <= POL7;
      an_q     <= POL4;
      dp_q     <= ACTIVE_LOW;
    end else begin
      if (!frozen_q) snap_q <= {sw.minutes, sw.seconds};
      if (sw.lap)    frozen_q <= ~frozen_q;
      dig_q <= dig_nxt;
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        idx_q <= idx_q + 2'd1;
        if (idx_q == 2'd3) blink_q <= ~blink_q;
      end else begin
        div_q <= div_q + DW'(1);
      end
      seg_q <= seg_code(dig_q[idx_q]) ^ POL7;
      an_q  <= (4'b0001 << idx_q) ^ POL4;
      dp_q  <= dp_on ^ ACTIVE_LOW;
    end
  end

  assign sw.seg    = seg_q;
  assign sw.an     = an_q;
  assign sw.dp     = dp_q;
  assign sw.frozen = frozen_q;
endmodule

// File: tb/tb_stopwatch_display.sv
// Two configurations (SCAN_DIV=4 active-low, SCAN_DIV=2 active-high) driven
// in lockstep; a time-based reference model predicts every pin each cycle.
module tb_stopwatch_display;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stopwatch_display_if if0 ();
  stopwatch_display_if if1 ();

  stopwatch_display #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut0 (.clk(clk), .reset(reset), .sw(if0.slave));
  stopwatch_display #(.SCAN_DIV(2), .ACTIVE_LOW(1'b0)) dut1 (.clk(clk), .reset(reset), .sw(if1.slave));

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       frozen;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model state per configuration: edges since reset, freeze flag,
  // value held in the snapshot now (cur) and one edge ago (prev).
  int j   [2];
  bit frz [2];
  int cs  [2], cm [2], ps [2], pm [2];

  function automatic int sdiv(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic bit alow(input int k);
    return (k == 0);
  endfunction

  function automatic logic [6:0] field_code(input int v, input bit tens);
    if (v > 59) return 7'h40;
    return tens ? segtab[v / 10] : segtab[v % 10];
  endfunction

  function automatic exp_t model_edge(input int k, input bit r, input int s, input int m,
                                      input bit rn, input bit lp);
    exp_t e;
    int   idx, jj, fv;
    bit   blink, fb, on;
    logic [6:0] p7;
    logic [3:0] p4;
    p7 = alow(k) ? 7'h7F : 7'h00;
    p4 = alow(k) ? 4'hF : 4'h0;
    if (r) begin
      j[k] = 0; frz[k] = 1'b0;
      cs[k] = 0; cm[k] = 0; ps[k] = 0; pm[k] = 0;
      e.seg = p7; e.an = p4; e.dp = alow(k); e.frozen = 1'b0;
      return e;
    end
    fb    = frz[k];
    j[k]  = j[k] + 1;
    jj    = j[k];
    idx   = ((jj - 1) / sdiv(k)) % 4;
    blink = (((jj - 1) / (4 * sdiv(k))) % 2) == 1;
    fv    = (idx < 2) ? ps[k] : pm[k];
    on    = (idx == 2) && (fb ? blink : rn);
    e.seg = field_code(fv, idx[0]) ^ p7;
    e.an  = 4'(1 << idx) ^ p4;
    e.dp  = on ^ alow(k);
    ps[k] = cs[k];
    pm[k] = cm[k];
    if (!fb) begin
      cs[k] = s;
      cm[k] = m;
    end
    frz[k]   = lp ? !fb : fb;
    e.frozen = frz[k];
    return e;
  endfunction

  task automatic step(input bit r, input int s, input int m, input bit rn, input bit lp);
    reset = r;
    if0.seconds = 6'(s); if0.minutes = 6'(m); if0.run = rn; if0.lap = lp;
    if1.seconds = 6'(s); if1.minutes = 6'(m); if1.run = rn; if1.lap = lp;
    @(posedge clk);
    q0.push_back(model_edge(0, r, s, m, rn, lp));
    q1.push_back(model_edge(1, r, s, m, rn, lp));
    #1;
  endtask

  task automatic hold(input int n, input int s, input int m, input bit rn);
    for (int i = 0; i < n; i++) step(1'b0, s, m, rn, 1'b0);
  endtask

  // Monitor: one expected pin vector per clock edge, checked mid-cycle.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        got = {if0.seg, if0.an, if0.dp, if0.frozen};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL pins_cfg0 t=%0t got seg=%h an=%b dp=%b frz=%b want seg=%h an=%b dp=%b frz=%b",
                   $time, got.seg, got.an, got.dp, got.frozen, e.seg, e.an, e.dp, e.frozen);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        got = {if1.seg, if1.an, if1.dp, if1.frozen};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL pins_cfg1 t=%0t got seg=%h an=%b dp=%b frz=%b want seg=%h an=%b dp=%b frz=%b",
                   $time, got.seg, got.an, got.dp, got.frozen, e.seg, e.an, e.dp, e.frozen);
        end
      end
    end
  end

  initial begin
    int s, m, guard;
    bit rn, lp, r;
    reset = 1'b1;
    if0.seconds = '0; if0.minutes = '0; if0.run = 1'b0; if0.lap = 1'b0;
    if1.seconds = '0; if1.minutes = '0; if1.run = 1'b0; if1.lap = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 1'b0, 1'b0);

    // 12:37 running, then stopped
    hold(36, 37, 12, 1'b1);
    hold(20, 37, 12, 1'b0);
    // 00:59 -> 01:00 rollover in one cycle
    hold(7, 59, 0, 1'b1);
    hold(10, 0, 1, 1'b1);
    // lap freeze at 00:05 while seconds count on, long enough to see blink
    hold(3, 5, 0, 1'b1);
    step(1'b0, 5, 0, 1'b1, 1'b1);
    for (int sec = 6; sec <= 9; sec++) hold(12, sec, 0, 1'b1);
    step(1'b0, 9, 0, 1'b1, 1'b1);
    hold(20, 9, 0, 1'b1);
    // out-of-range seconds
    hold(20, 61, 3, 1'b1);
    hold(20, 33, 63, 1'b0);
    // reset together with lap while dut0 is scanning digit 2
    guard = 0;
    while (((j[0] / 4) % 4) != 2 && guard < 64) begin
      step(1'b0, 44, 7, 1'b1, 1'b0);
      guard++;
    end
    step(1'b0, 44, 7, 1'b1, 1'b1);
    step(1'b1, 44, 7, 1'b1, 1'b1);
    hold(20, 44, 7, 1'b1);
    // lap held high toggles every cycle
    for (int i = 0; i < 5; i++) step(1'b0, 10 + i, 2, 1'b1, 1'b1);
    hold(10, 20, 2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      s  = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
      m  = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
      rn = $urandom_range(0, 3) != 0;
      lp = $urandom_range(0, 15) == 0;
      r  = $urandom_range(0, 199) == 0;
      step(r, s, m, rn, lp);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Downstream consumer of the stopwatch counter. Takes binary seconds/minutes and the run flag, and converts them to BCD.
- Drives a 4-digit multiplexed 7-segment display as MM.SS. A lap input freezes the shown value while the counter keeps running.
- Sits between the stopwatch core and the board display pins.

Parameters:
- SCAN_DIV, 4: clk cycles each digit stays enabled; legal 2..2^16.
- ACTIVE_LOW, 1: 1 = seg, an and dp are active-low at the pins; 0 = active-high.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- seconds  input  6  binary seconds from stopwatch core, nominal 0..59
- minutes  input  6  binary minutes from stopwatch core, nominal 0..59
- run  input  1  core running flag
- lap  input  1  single-cycle pulse; toggles freeze of displayed value
- seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}
- an  output  4  digit enables, one-hot; bit0 = seconds ones … bit3 = minutes tens
- dp  output  1  decimal point (separator shown right of digit 2)
- frozen  output  1  1 while lap freeze is active

Behaviour:
- All logic on posedge clk. Reset is synchronous, active-high, and has priority over every other input, including lap in the same cycle.
- Reset values (pin level shown for ACTIVE_LOW=1):
  - seg = 7'h7F (all off), an = 4'hF, dp = 1.
  - frozen = 0, snapshot registers = 0, digit registers = 0, scan divider = 0, digit index = 0.
- Snapshot stage:
  - Each cycle with frozen=0: snap_s <= seconds, snap_m <= minutes.
  - With frozen=1: snap_s and snap_m hold.
- Lap:
  - lap=1 with frozen=0: frozen <= 1. The snapshot captures the seconds/minutes present in that same cycle.
  - lap=1 with frozen=1: frozen <= 0. Live tracking resumes from the next cycle.
  - lap held high toggles every cycle; lap is not edge-detected internally.
- BCD stage:
  - From snap_s and snap_m: tens = v/10 and ones = v%10, computed combinationally and registered into 4 digit registers.
  - Latency from input to digit register: 2 cycles.
  - Out-of-range value (60..63): both digits of that field are registered as the DASH code.
- Scan:
  - Divider counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index advances 0→1→2→3→0.
  - Each digit is enabled for exactly SCAN_DIV consecutive cycles; one full frame = 4*SCAN_DIV cycles.
- Output register: each non-reset cycle, seg/an/dp are driven from the current index and its digit register. Outputs are registered, with no combinational path from inputs to pins.
- an, internal active-high: index 0 → 0001, 1 → 0010, 2 → 0100, 3 → 1000. Inverted at the pins when ACTIVE_LOW=1.
- Segment codes, internal active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - DASH=40.
  - Inverted at the pins when ACTIVE_LOW=1.
- dp:
  - Lit only while index=2 and run=1 and frozen=0.
  - Lit only while index=2 and frozen=1, gated by a blink bit that toggles once per full frame.
  - Otherwise off.
- A digit change lands on the pins at the next output register update. No blanking between digits is required.
- Reset mid-frame: outputs go to the off state the next cycle. The scan restarts at index 0 with a full SCAN_DIV dwell.

Test Plan:
- Reset, then minutes=12, seconds=37 (ACTIVE_LOW=1, SCAN_DIV=4) → within 3 cycles the frame shows, each for 4 cycles:
  - an=1110 seg=7'h78
  - an=1101 seg=7'h30
  - an=1011 seg=7'h24
  - an=0111 seg=7'h79
  - dp=0 only while an=1011 with run=1.
- Step seconds 59→0 and minutes 0→1 across one cycle → digit registers show 01:00 two cycles after the input change, with no intermediate value on the pins.
- lap pulse while seconds=5, then seconds counts to 9 → display stays 00:05 and frozen=1. Second lap pulse → frozen=0 and digit registers = 00:09 two cycles later.
- seconds=61, minutes=3 → seconds digits seg=7'h3F (dash). Minutes digits show 03: seg=7'h40 then 7'h30.
- Assert reset mid-frame (index=2) together with lap → next cycle seg=7'h7F, an=4'hF, dp=1, frozen=0. The first post-reset digit is index 0 for 4 cycles.
- Dwell check with SCAN_DIV=2 and ACTIVE_LOW=0 → each an bit is high for exactly 2 cycles; an is active-high one-hot; blank seg=7'h00.
